id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/core_pkg.sv | 48 ++++
 rtl/pipe_reg.sv | 28 ++
 rtl/id_ex_register.sv | 112 +++++++++++
 tb/tb_id_ex_register.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, ID/EX control bus and its field encodings.
// Used by the decoder and by the ID/EX pipeline register.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // ALU intent: how EX should interpret funct3/funct7 for this instruction.
  localparam logic [1:0] AluIntentAdd = 2'b00;
  localparam logic [1:0] AluIntentSub = 2'b01;
  localparam logic [1:0] AluIntentRty = 2'b10;
  localparam logic [1:0] AluIntentIty = 2'b11;

  // Writeback source select.
  localparam logic [1:0] WbSrcAlu = 2'b00;
  localparam logic [1:0] WbSrcPc4 = 2'b01;
  localparam logic [1:0] WbSrcMem = 2'b10;

  // Field order is the bit order of the 12-bit bus, MSB first.
  typedef struct packed {
    logic       is_halt;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       mem_write_en;
    logic       mem_read_en;
    logic       reg_write_en;
    logic [1:0] rd_src_optn;
    logic [1:0] alu_intent;
    logic       alu_src_optn;
  } id_ex_ctrl_t;

  localparam int unsigned CtrlW = $bits(id_ex_ctrl_t);

  // Control as latched into EX: bubbles carry no side effects and writes to x0 are dropped.
  function automatic id_ex_ctrl_t ex_ctrl_filter(input logic valid, input id_ex_ctrl_t ctrl,
                                                 input logic [4:0] rd_addr);
    id_ex_ctrl_t res;
    res = '0;
    if (valid) begin
      res = ctrl;
      if (rd_addr == 5'd0) begin
        res.reg_write_en = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline payload register: async reset, synchronous clear (bubble), load enable.
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  // Clear wins over load so a flush overrides any enable state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush and a halt latch that freezes the stage
// once a halt instruction has been captured into EX.
module id_ex_register #(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  core_pkg::id_ex_ctrl_t ctrl_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_b5_i,
  output logic                  ex_valid_o,
  output core_pkg::id_ex_ctrl_t ex_ctrl_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_imm_o,
  output logic [4:0]            ex_rs1_addr_o,
  output logic [4:0]            ex_rs2_addr_o,
  output logic [4:0]            ex_rd_addr_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  ex_funct7_b5_o,
  output logic                  halted_o
);

  import core_pkg::*;

  localparam int unsigned PayloadW = 1 + CtrlW + 4 * XLEN + 3 * 5 + 3 + 1;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e state_q, state_d;

  logic                payload_en;
  logic                payload_clr;
  id_ex_ctrl_t         ctrl_cap;
  logic [PayloadW-1:0] payload_d;
  logic [PayloadW-1:0] payload_q;

  // Halt state register; leaves HALTED only through reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt is taken only on a genuine capture edge, never while stalled or flushed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (!flush_i && !stall_i && valid_i && ctrl_i.is_halt) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // Payload control: frozen entirely while halted, otherwise flush > stall > capture.
  always_comb begin
    payload_en  = 1'b0;
    payload_clr = 1'b0;
    halted_o    = 1'b0;
    unique case (state_q)
      StRun: begin
        payload_clr = flush_i;
        payload_en  = !stall_i;
      end
      StHalted: halted_o = 1'b1;
      default: begin
        payload_en  = 1'b0;
        payload_clr = 1'b0;
      end
    endcase
  end

  // Control bus as it should appear in EX.
  always_comb begin
    ctrl_cap = ex_ctrl_filter(valid_i, ctrl_i, rd_addr_i);
  end

  assign payload_d = {valid_i, ctrl_cap, pc_i, rs1_data_i, rs2_data_i, imm_i,
                      rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_b5_i};

  pipe_reg #(
    .Width (PayloadW)
  ) u_payload (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (payload_en),
    .clr_i (payload_clr),
    .d_i   (payload_d),
    .q_o   (payload_q)
  );

  assign {ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
          ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_funct3_o, ex_funct7_b5_o} = payload_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry per clock edge or reset assertion.
module tb_id_ex_register;

  localparam int unsigned W = 32;

  // Control encodings, bit order: halt,br,jal,jalr,mw,mr,rw,rd_src[1:0],alu_int[1:0],alu_src
  localparam logic [11:0] CtrlLoad     = 12'h071;
  localparam logic [11:0] CtrlStore    = 12'h081;
  localparam logic [11:0] CtrlRtype    = 12'h024;
  localparam logic [11:0] CtrlRtypeX0  = 12'h004;
  localparam logic [11:0] CtrlEcall    = 12'h800;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [11:0] ctrl;
    logic [W-1:0] pc;
    logic [W-1:0] rs1d;
    logic [W-1:0] rs2d;
    logic [W-1:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [2:0]  f3;
    logic        f7;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [W-1:0] pc;
    logic [W-1:0] rs1d;
    logic [W-1:0] rs2d;
    logic [W-1:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [2:0]  f3;
    logic        f7;
    logic        halted;
  } out_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i, flush_i, valid_i, funct7_b5_i;
  logic [11:0] ctrl_i;
  logic [W-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]  funct3_i;
  logic        ex_valid_o, ex_funct7_b5_o, halted_o;
  logic [11:0] ex_ctrl_o;
  logic [W-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [2:0]  ex_funct3_o;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  id_ex_register #(
    .XLEN (W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ctrl_i         (ctrl_i),
    .pc_i           (pc_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .imm_i          (imm_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rd_addr_i      (rd_addr_i),
    .funct3_i       (funct3_i),
    .funct7_b5_i    (funct7_b5_i),
    .ex_valid_o     (ex_valid_o),
    .ex_ctrl_o      (ex_ctrl_o),
    .ex_pc_o        (ex_pc_o),
    .ex_rs1_data_o  (ex_rs1_data_o),
    .ex_rs2_data_o  (ex_rs2_data_o),
    .ex_imm_o       (ex_imm_o),
    .ex_rs1_addr_o  (ex_rs1_addr_o),
    .ex_rs2_addr_o  (ex_rs2_addr_o),
    .ex_rd_addr_o   (ex_rd_addr_o),
    .ex_funct3_o    (ex_funct3_o),
    .ex_funct7_b5_o (ex_funct7_b5_o),
    .halted_o       (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected EX contents for a captured vector: data fields pass through, valid/ctrl given.
  function automatic out_t pass(input in_t v, input logic valid, input logic [11:0] ctrl,
                                input logic halted);
    out_t o;
    o = '{valid: valid, ctrl: ctrl, pc: v.pc, rs1d: v.rs1d, rs2d: v.rs2d, imm: v.imm,
          rs1a: v.rs1a, rs2a: v.rs2a, rda: v.rda, f3: v.f3, f7: v.f7, halted: halted};
    return o;
  endfunction

  function automatic in_t vec(input logic stall, input logic flush, input logic valid,
                              input logic [11:0] ctrl, input logic [W-1:0] base,
                              input logic [4:0] rd);
    in_t v;
    v = '{stall: stall, flush: flush, valid: valid, ctrl: ctrl, pc: base,
          rs1d: base + 32'h11, rs2d: base + 32'h22, imm: base + 32'h33,
          rs1a: 5'd1, rs2a: 5'd2, rda: rd, f3: 3'b101, f7: 1'b1};
    return v;
  endfunction

  // Drive one vector before the next rising edge and queue what EX must show after it.
  task automatic drive(input string name, input in_t v, input out_t e);
    @(negedge clk_i);
    stall_i     = v.stall;
    flush_i     = v.flush;
    valid_i     = v.valid;
    ctrl_i      = v.ctrl;
    pc_i        = v.pc;
    rs1_data_i  = v.rs1d;
    rs2_data_i  = v.rs2d;
    imm_i       = v.imm;
    rs1_addr_i  = v.rs1a;
    rs2_addr_i  = v.rs2a;
    rd_addr_i   = v.rda;
    funct3_i    = v.f3;
    funct7_b5_i = v.f7;
    sb_q.push_back('{name: name, exp: e});
  endtask

  // Monitor: one pop per clock edge or reset assertion, sampled 1ns later.
  initial begin
    sb_t  s;
    out_t act;
    forever begin
      @(posedge clk_i or posedge rst_i);
      #1;
      if (sb_q.size() > 0) begin
        s   = sb_q.pop_front();
        act = '{valid: ex_valid_o, ctrl: ex_ctrl_o, pc: ex_pc_o, rs1d: ex_rs1_data_o,
                rs2d: ex_rs2_data_o, imm: ex_imm_o, rs1a: ex_rs1_addr_o,
                rs2a: ex_rs2_addr_o, rda: ex_rd_addr_o, f3: ex_funct3_o,
                f7: ex_funct7_b5_o, halted: halted_o};
        checks++;
        if (act !== s.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
        end
      end
    end
  end

  initial begin
    in_t  v;
    out_t hold;
    out_t zero;
    zero = '0;

    v = '0;
    {stall_i, flush_i, valid_i, funct7_b5_i} = '0;
    ctrl_i = '0;
    {pc_i, rs1_data_i, rs2_data_i, imm_i} = '0;
    {rs1_addr_i, rs2_addr_i, rd_addr_i} = '0;
    funct3_i = '0;

    // Reset with no clock edge involved.
    #2;
    sb_q.push_back('{name: "reset", exp: zero});
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // LOAD capture.
    v = vec(1'b0, 1'b0, 1'b1, CtrlLoad, 32'h100, 5'd5);
    v.imm = 32'h10;
    hold = pass(v, 1'b1, CtrlLoad, 1'b0);
    drive("capture_load", v, hold);

    // Stall three cycles while inputs change.
    for (int i = 0; i < 3; i++) begin
      drive("stall_hold", vec(1'b1, 1'b0, 1'b1, CtrlStore, 32'h200 + i * 32'h40, 5'd9), hold);
    end

    // Flush with simultaneous stall on a valid R-type.
    drive("flush_over_stall", vec(1'b1, 1'b1, 1'b1, CtrlRtype, 32'h300, 5'd6), zero);

    // R-type writing x0.
    v = vec(1'b0, 1'b0, 1'b1, CtrlRtype, 32'h400, 5'd0);
    drive("rtype_x0", v, pass(v, 1'b1, CtrlRtypeX0, 1'b0));

    // Invalid slot: data captured, control forced to zero.
    v = vec(1'b0, 1'b0, 1'b0, CtrlStore, 32'h500, 5'd3);
    drive("invalid_capture", v, pass(v, 1'b0, 12'h000, 1'b0));

    // Plain flush of a valid store.
    drive("flush_only", vec(1'b0, 1'b1, 1'b1, CtrlStore, 32'h580, 5'd4), zero);

    // R-type with a real destination.
    v = vec(1'b0, 1'b0, 1'b1, CtrlRtype, 32'h600, 5'd7);
    hold = pass(v, 1'b1, CtrlRtype, 1'b0);
    drive("rtype_rd7", v, hold);

    // Ecall under stall must not halt.
    v = vec(1'b1, 1'b0, 1'b1, CtrlEcall, 32'h700, 5'd0);
    drive("ecall_stalled", v, hold);

    // Stall released: ecall captured and halted on the same edge.
    v.stall = 1'b0;
    hold = pass(v, 1'b1, CtrlEcall, 1'b1);
    drive("ecall_halt", v, hold);

    // Halted: flush and new inputs ignored.
    for (int i = 0; i < 4; i++) begin
      drive("halted_hold", vec(1'b0, 1'b1, 1'b1, CtrlLoad, 32'h800 + i * 32'h40, 5'd8), hold);
    end

    // Asynchronous reset pulse between clock edges.
    @(posedge clk_i);
    #3;
    sb_q.push_back('{name: "async_reset", exp: zero});
    rst_i = 1'b1;
    #4;
    rst_i = 1'b0;

    // Back in RUN: normal capture resumes.
    v = vec(1'b0, 1'b0, 1'b1, CtrlLoad, 32'h900, 5'd12);
    drive("capture_after_reset", v, pass(v, 1'b1, CtrlLoad, 1'b0));

    // Every queued expectation must have been consumed by now.
    @(posedge clk_i);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #5000;
    $display("FAIL timeout: got no finish expected finish by 5000");
    $fatal(1, "timeout");
  end

endmodule
